// File: rtl/ncca_err_sweep.sv
// Exhaustive 8x8 multiplier error sweep: drives all 65536 operand pairs, aligns the
// returned product with a DUT_LAT-deep operand delay line and accumulates error stats.
module ncca_err_sweep #(
  parameter int DUT_LAT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [7:0]  approx_a,
  output logic [7:0]  approx_b,
  input  logic [15:0] approx_prod,
  output logic        busy,
  output logic        done,
  output logic [16:0] err_count,
  output logic [16:0] over_count,
  output logic [31:0] sum_abs_err,
  output logic [15:0] max_abs_err,
  output logic [7:0]  max_err_a,
  output logic [7:0]  max_err_b
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SWEEP,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic        launch;
  logic        finish;
  logic        op_valid;
  logic        last_pair;
  logic        pipe_busy;
  logic        cmp_valid;
  logic [7:0]  cmp_a, cmp_b;
  logic [15:0] exact;
  logic [16:0] diff, diff_neg;
  logic [15:0] abs_err;
  logic        over;

  assign last_pair = ({approx_a, approx_b} == 16'hFFFF);
  assign busy      = (state_q == S_SWEEP) || (state_q == S_DRAIN);

  // NOTE: sequential state is written only with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_SWEEP;
          launch  = 1'b1;
        end
      end
      S_SWEEP: begin
        if (last_pair) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (!pipe_busy) begin
          state_d = S_DONE;
          finish  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand counter doubles as stage 0 of the alignment delay line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      approx_a <= 8'd0;
      approx_b <= 8'd0;
      op_valid <= 1'b0;
    end else if (launch) begin
      approx_a <= 8'd0;
      approx_b <= 8'd0;
      op_valid <= 1'b1;
    end else if (state_q == S_SWEEP) begin
      if (last_pair) begin
        approx_a <= 8'd0;
        approx_b <= 8'd0;
        op_valid <= 1'b0;
      end else begin
        {approx_a, approx_b} <= {approx_a, approx_b} + 16'd1;
      end
    end
  end

  generate
    if (DUT_LAT == 0) begin : g_nodly
      assign cmp_a     = approx_a;
      assign cmp_b     = approx_b;
      assign cmp_valid = op_valid;
      assign pipe_busy = op_valid;
    end else begin : g_dly
      logic [7:0]         dly_a [DUT_LAT];
      logic [7:0]         dly_b [DUT_LAT];
      logic [DUT_LAT-1:0] dly_v;

      // NOTE: the operand copies carry no reset; only the valid bits need a known
      // value, and an unreset data path is cheaper and never observed while invalid.
      always_ff @(posedge clk) begin
        dly_a[0] <= approx_a;
        dly_b[0] <= approx_b;
        for (int i = 1; i < DUT_LAT; i++) begin
          dly_a[i] <= dly_a[i-1];
          dly_b[i] <= dly_b[i-1];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dly_v <= '0;
        end else begin
          dly_v[0] <= op_valid;
          for (int i = 1; i < DUT_LAT; i++) dly_v[i] <= dly_v[i-1];
        end
      end

      assign cmp_a     = dly_a[DUT_LAT-1];
      assign cmp_b     = dly_b[DUT_LAT-1];
      assign cmp_valid = dly_v[DUT_LAT-1];
      assign pipe_busy = op_valid | (|dly_v);
    end
  endgenerate

  // Both magnitudes fit in 16 bits, so a 17-bit difference carries a correct sign.
  assign exact    = {8'd0, cmp_a} * {8'd0, cmp_b};
  assign diff     = {1'b0, approx_prod} - {1'b0, exact};
  assign diff_neg = 17'd0 - diff;
  assign abs_err  = diff[16] ? diff_neg[15:0] : diff[15:0];
  assign over     = (approx_prod > exact);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count   <= 17'd0;
      over_count  <= 17'd0;
      sum_abs_err <= 32'd0;
      max_abs_err <= 16'd0;
      max_err_a   <= 8'd0;
      max_err_b   <= 8'd0;
    end else if (launch) begin
      err_count   <= 17'd0;
      over_count  <= 17'd0;
      sum_abs_err <= 32'd0;
      max_abs_err <= 16'd0;
      max_err_a   <= 8'd0;
      max_err_b   <= 8'd0;
    end else if (cmp_valid) begin
      err_count   <= err_count + {16'd0, |abs_err};
      over_count  <= over_count + {16'd0, over};
      sum_abs_err <= sum_abs_err + {16'd0, abs_err};
      // Strict compare keeps the earliest pair on ties.
      if (abs_err > max_abs_err) begin
        max_abs_err <= abs_err;
        max_err_a   <= cmp_a;
        max_err_b   <= cmp_b;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done <= 1'b0;
    else        done <= finish;
  end

endmodule

// File: tb/tb_ncca_err_sweep.sv
// Bench for ncca_err_sweep: seven sweep engines run side by side against different
// multiplier models; expected statistics come from a per-pair arithmetic reference.
module tb_ncca_err_sweep;

  localparam int NI         = 7;
  localparam int SWEEP_CLKS = 65537;

  // Instance roles: 0 exact, 1 single fault, 2 LSB cleared, 3 random faults,
  // 4 DUT_LAT=2 with two-register exact multiplier, 5 DUT_LAT=0 with the same
  // two-register multiplier, 6 random faults with a reset part-way through.
  typedef struct {
    logic [16:0] err;
    logic [16:0] over;
    logic [31:0] sum;
    logic [15:0] mx;
    logic [7:0]  ma;
    logic [7:0]  mb;
    longint      done_cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n_s [NI];
  logic        start_s [NI];
  logic [7:0]  a_s     [NI];
  logic [7:0]  b_s     [NI];
  logic [15:0] prod_s  [NI];
  logic        busy_s  [NI];
  logic        done_s  [NI];
  logic [16:0] err_s   [NI];
  logic [16:0] over_s  [NI];
  logic [31:0] sum_s   [NI];
  logic [15:0] max_s   [NI];
  logic [7:0]  ma_s    [NI];
  logic [7:0]  mb_s    [NI];

  logic [15:0] pert_val [65536];
  bit          pert_en  [65536];

  exp_t   exp_q [NI][$];
  exp_t   last_exp [NI];
  int     checks   = 0;
  int     failures = 0;
  int     ndone    = 0;
  longint cyc      = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic int lat_of(int g);
    return (g == 4) ? 2 : 0;
  endfunction

  // Product returned by the combinational multiplier models.
  function automatic logic [15:0] drive_prod(int g, logic [7:0] a, logic [7:0] b);
    int e;
    int n;
    e = int'(a) * int'(b);
    n = int'({a, b});
    case (g)
      1:       if (a == 8'd3 && b == 8'd5) e = e + 1;
      2:       e = e & 32'hFFFE;
      3, 6:    if (pert_en[n]) e = int'(pert_val[n]);
      default: ;
    endcase
    return 16'(e);
  endfunction

  // Product observed in the compare slot of pair n.
  function automatic int model_approx(int g, int n);
    int m;
    case (g)
      4: return (n >> 8) * (n & 255);
      5: begin
        // two registers seen with no alignment: slot n carries pair n-2, zero before start
        if (n < 2) return 0;
        m = n - 2;
        return (m >> 8) * (m & 255);
      end
      default: return int'(drive_prod(g, 8'(n >> 8), 8'(n & 255)));
    endcase
  endfunction

  function automatic exp_t ref_stats(int g, longint done_cyc);
    exp_t   s;
    longint sum = 0;
    int     err = 0, over = 0, mx = 0, ma = 0, mb = 0;
    int     ex, ap, d;
    for (int n = 0; n < 65536; n++) begin
      ex = (n >> 8) * (n & 255);
      ap = model_approx(g, n);
      d  = (ap > ex) ? ap - ex : ex - ap;
      if (d != 0) err++;
      if (ap > ex) over++;
      sum += d;
      if (d > mx) begin
        mx = d;
        ma = n >> 8;
        mb = n & 255;
      end
    end
    s.err      = 17'(err);
    s.over     = 17'(over);
    s.sum      = 32'(sum);
    s.mx       = 16'(mx);
    s.ma       = 8'(ma);
    s.mb       = 8'(mb);
    s.done_cyc = done_cyc;
    return s;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_inst
    logic [15:0] r1, r2;

    ncca_err_sweep #(.DUT_LAT(g == 4 ? 2 : 0)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n_s[g]),
      .start       (start_s[g]),
      .approx_a    (a_s[g]),
      .approx_b    (b_s[g]),
      .approx_prod (prod_s[g]),
      .busy        (busy_s[g]),
      .done        (done_s[g]),
      .err_count   (err_s[g]),
      .over_count  (over_s[g]),
      .sum_abs_err (sum_s[g]),
      .max_abs_err (max_s[g]),
      .max_err_a   (ma_s[g]),
      .max_err_b   (mb_s[g])
    );

    always @(posedge clk) begin
      r1 <= {8'd0, a_s[g]} * {8'd0, b_s[g]};
      r2 <= r1;
    end

    assign prod_s[g] = (g == 4 || g == 5) ? r2 : drive_prod(g, a_s[g], b_s[g]);

    // Monitor: every done pulse is matched against the oldest outstanding expectation.
    always @(negedge clk) begin
      exp_t e;
      if (rst_n_s[g] && done_s[g]) begin
        if (exp_q[g].size() == 0) begin
          check($sformatf("unexpected_done[%0d]", g), 64'(done_s[g]), 64'd0);
        end else begin
          e = exp_q[g].pop_front();
          check($sformatf("done_cycle[%0d]", g), 64'(cyc), 64'(e.done_cyc));
          check($sformatf("busy_at_done[%0d]", g), 64'(busy_s[g]), 64'd0);
          check($sformatf("err_count[%0d]", g), 64'(err_s[g]), 64'(e.err));
          check($sformatf("over_count[%0d]", g), 64'(over_s[g]), 64'(e.over));
          check($sformatf("sum_abs_err[%0d]", g), 64'(sum_s[g]), 64'(e.sum));
          check($sformatf("max_abs_err[%0d]", g), 64'(max_s[g]), 64'(e.mx));
          check($sformatf("max_err_ab[%0d]", g), 64'({ma_s[g], mb_s[g]}), 64'({e.ma, e.mb}));
          last_exp[g] = e;
          ndone++;
        end
      end
    end
  end

  task automatic check_zero(input int g, input string tag);
    check($sformatf("%s_ctl[%0d]", tag, g),
          64'({a_s[g], b_s[g], busy_s[g], done_s[g], ma_s[g], mb_s[g]}), 64'd0);
    check($sformatf("%s_cnt[%0d]", tag, g), 64'({err_s[g], over_s[g], max_s[g]}), 64'd0);
    check($sformatf("%s_sum[%0d]", tag, g), 64'(sum_s[g]), 64'd0);
  endtask

  initial begin
    longint k;
    longint m;
    int     budget;
    int     e, v;

    for (int n = 0; n < 65536; n++) begin
      e = (n >> 8) * (n & 255);
      pert_en[n] = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 1) == 1) begin
        v = e + int'($urandom_range(0, 6)) - 3;
        if (v < 0) v = 0;
        if (v > 65535) v = 65535;
      end else begin
        v = int'($urandom_range(0, 65535));
      end
      pert_val[n] = 16'(v);
    end

    for (int g = 0; g < NI; g++) begin
      rst_n_s[g] = 1'b0;
      start_s[g] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < NI; g++) check_zero(g, "reset");
    for (int g = 0; g < NI; g++) rst_n_s[g] = 1'b1;
    repeat (3) @(negedge clk);

    for (int g = 0; g < NI; g++) begin
      start_s[g] = 1'b1;
      exp_q[g].push_back(ref_stats(g, cyc + 1 + SWEEP_CLKS + lat_of(g)));
    end
    k = cyc + 1;
    @(negedge clk);
    for (int g = 0; g < NI; g++) start_s[g] = 1'b0;
    check("first_pair", 64'({busy_s[0], a_s[0], b_s[0]}), 64'({1'b1, 16'h0000}));

    while (cyc < k + 1000) begin
      @(negedge clk);
      m = cyc - k;
      if (m == 1 || m == 255 || m == 256 || m == 502)
        check($sformatf("operands_n%0d", m), 64'({a_s[0], b_s[0]}), 64'(m));
      if (m == 500) start_s[0] = 1'b1;
      if (m == 501) start_s[0] = 1'b0;
    end

    #2 rst_n_s[6] = 1'b0;
    #1 check_zero(6, "midreset");
    exp_q[6].delete();
    @(negedge clk);
    check_zero(6, "midreset_held");
    rst_n_s[6] = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_after_reset", 64'({busy_s[6], a_s[6], b_s[6]}), 64'd0);
    start_s[6] = 1'b1;
    exp_q[6].push_back(ref_stats(6, cyc + 1 + SWEEP_CLKS));
    @(negedge clk);
    start_s[6] = 1'b0;

    budget = 70000;
    while (ndone < NI && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("all_sweeps_done", 64'(ndone), 64'(NI));

    repeat (3) @(negedge clk);
    check("done_hold_ctl", 64'({done_s[1], busy_s[1]}), 64'd0);
    check("done_hold_err", 64'(err_s[1]), 64'(last_exp[1].err));
    check("done_hold_max_ab", 64'({max_s[1], ma_s[1], mb_s[1]}),
          64'({last_exp[1].mx, last_exp[1].ma, last_exp[1].mb}));
    start_s[1] = 1'b1;
    @(negedge clk);
    start_s[1] = 1'b0;
    check("restart_busy_ops", 64'({busy_s[1], a_s[1], b_s[1]}), 64'({1'b1, 16'h0000}));
    check("restart_clear_cnt", 64'({err_s[1], over_s[1], max_s[1]}), 64'd0);
    check("restart_clear_sum_ab", 64'({sum_s[1], ma_s[1], mb_s[1]}), 64'd0);
    @(negedge clk);
    check("restart_advance", 64'({a_s[1], b_s[1]}), 64'h0001);

    for (int g = 0; g < NI; g++) rst_n_s[g] = 1'b0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ncca_err_sweep.md
# ncca_err_sweep

Exhaustive error-characterisation engine for the 8x8 approximate multipliers (NCCA family, e.g. the 2/4/4/4 LUT2 configuration). It sits on the operand side of a multiplier under test. It drives every (a, b) pair from (0,0) to (255,255), one pair per clock, and receives the approximate product back. It compares that product with the exact product and accumulates error statistics that software reads after `done`.

## Interface
- `DUT_LAT`, default 0: multiplier latency in clocks from operand change to valid product. 0 means a purely combinational multiplier. Legal range is 0..4.
- `clk` input, 1 bit: single clock. All state updates on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `start` input, 1 bit: request a sweep. Sampled only in IDLE or DONE.
- `approx_a` output, 8 bits: operand a to the multiplier under test. Registered.
- `approx_b` output, 8 bits: operand b to the multiplier under test. Registered.
- `approx_prod` input, 16 bits: product returned by the multiplier under test.
- `busy` output, 1 bit: high while a sweep or drain is in progress.
- `done` output, 1 bit: one-cycle pulse when the final statistics are valid.
- `err_count` output, 17 bits: number of pairs with approx_prod ≠ a*b.
- `over_count` output, 17 bits: number of pairs with approx_prod > a*b.
- `sum_abs_err` output, 32 bits: Σ|approx_prod − a*b|.
- `max_abs_err` output, 16 bits: largest |approx_prod − a*b|.
- `max_err_a` output, 8 bits: operand a of the first pair reaching `max_abs_err`.
- `max_err_b` output, 8 bits: operand b of the first pair reaching `max_abs_err`.

## Operation
- The FSM has four states: IDLE, SWEEP, DRAIN, DONE. Reset enters IDLE.
- IDLE or DONE, with `start`=1: clear all statistics, set operands to (0,0), go to SWEEP, set `busy`=1.
- SWEEP: each clock advances the pair index n = a·256 + b by one. b is the inner loop and a the outer loop; b wraps 255→0 and increments a.
  - After pair (255,255) has been issued, go to DRAIN.
  - The operands then return to (0,0) and hold there.
- Operand tracking:
  - An internal delay line of DUT_LAT+1 stages carries (a, b, valid) alongside the multiplier.
  - The stage-(DUT_LAT) copy is used to form the exact 16-bit product a*b and is compared with `approx_prod`.
- Error arithmetic: abs_err = |approx_prod − exact|, computed in 17-bit signed arithmetic and truncated to 16 bits. The result cannot exceed 65535.
- Accumulation on each valid compare:
  - `err_count` += (abs_err≠0).
  - `over_count` += (approx_prod>exact).
  - `sum_abs_err` += abs_err.
  - The maximum and its operands update only when abs_err > max_abs_err (strictly greater). Ties therefore keep the earliest pair in sweep order.
  - No counter can overflow: err_count ≤ 65536 and sum ≤ 65536·65535 < 2³².
- DRAIN lasts until the last valid compare has been accumulated. Then `done` pulses, `busy` falls, and the FSM goes to DONE.
- DONE: statistics hold until the next `start` or reset.
- `start` during SWEEP or DRAIN is ignored.
- `rst_n` low at any time, including mid-sweep, immediately returns every output to its reset value and the FSM to IDLE. A partial sweep is discarded.

## Timing
- Reset value of every output is 0: approx_a, approx_b, busy, done, and all statistics.
- With `start` sampled high at edge k:
  - busy=1 and (a,b)=(0,0) from edge k.
  - Pair n is driven from edge k+n.
  - Its product is sampled and accumulated at edge k+n+1+DUT_LAT.
- The last accumulation is at edge k+65536+DUT_LAT.
- At edge k+65537+DUT_LAT: done=1 for one cycle, busy=0, and the statistics are final and stable.
- Start-to-done is 65537+DUT_LAT clocks.
- If `start` is held high in DONE, a new sweep begins on the next edge. The statistics clear on that same edge.
- `approx_prod` must be settled DUT_LAT cycles after the operands change. It is never sampled outside a valid compare slot.

## Test plan
- Exact model (approx_prod = a*b, DUT_LAT=0): start → err_count=0, over_count=0, sum_abs_err=0, max_abs_err=0, max_err_a/b=0; done exactly 65537 clocks after start.
- Single fault (prod = a*b+1 only at a=3, b=5): err_count=1, over_count=1, sum=1, max=1, max_err_a=3, max_err_b=5.
- LSB-cleared model (prod = (a*b) & 16'hFFFE): err_count=16384, over_count=0, sum=16384, max=1, max_err=(1,1). This checks the first-occurrence tie rule.
- DUT_LAT=2 with the exact product passed through two registers: zero errors; done at 65539 clocks. Repeat with DUT_LAT=0 against the same 2-stage model: err_count>0, which confirms that the alignment matters.
- Reset mid-sweep: drop rst_n at clock 1000 → all outputs 0 and FSM in IDLE. A following start completes the full sweep with correct stats.
- start pulsed at clock 500 of a sweep: ignored, done timing unchanged. start in DONE: stats cleared on the next edge, and the second sweep gives identical results.
